// File: rtl/fib_seq_ctrl.sv
// Fibonacci sequencer controller: sequences ALU opcode, register-file indices and write enable.
// Optional iteration cap is compiled in by defining FIB_SEQ_ITER_LIMIT_EN.
module fib_seq_ctrl #(
  parameter  int NREG     = 3,
  parameter  int CW       = 8,
  parameter  int MAX_ITER = 200,
  localparam int IW       = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          mayor,
  output logic [1:0]    alu_op,
  output logic [IW-1:0] sel_a,
  output logic [IW-1:0] sel_b,
  output logic [IW-1:0] sel_w,
  output logic          we,
  output logic          busy,
  output logic          done,
  output logic          ovf,
  output logic [CW-1:0] iter_count,
  output logic [IW-1:0] res_idx
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT0, S_INIT1, S_SELECT, S_ADD, S_WRITE, S_CMP, S_DONE
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_HOLD = 2'b01,
    OP_ZERO = 2'b10,
    OP_ONE  = 2'b11
  } op_t;

`ifdef FIB_SEQ_ITER_LIMIT_EN
  localparam bit CAP_EN = 1'b1;
`else
  localparam bit CAP_EN = 1'b0;
`endif

  localparam logic [IW-1:0] PTR_A0   = IW'(0);
  localparam logic [IW-1:0] PTR_B0   = IW'(1);
  localparam logic [IW-1:0] PTR_W0   = IW'(2);
  localparam logic [IW-1:0] PTR_LAST = IW'(NREG - 1);
  localparam logic [CW-1:0] ITER_SAT = '1;
  localparam logic [CW-1:0] ITER_CAP = CW'(MAX_ITER);

  state_t        state_q, state_d;
  logic [IW-1:0] ptr_a_q, ptr_a_d;
  logic [IW-1:0] ptr_b_q, ptr_b_d;
  logic [IW-1:0] ptr_w_q, ptr_w_d;
  logic [CW-1:0] iter_q,  iter_d;
  logic          ovf_q,   ovf_d;
  logic [IW-1:0] res_q,   res_d;
  logic          cap_hit;

  assign cap_hit = CAP_EN && (iter_q == ITER_CAP);

  always_comb begin
    // NOTE: every *_d starts from its *_q so no path through the case can infer a latch.
    state_d = state_q;
    ptr_a_d = ptr_a_q;
    ptr_b_d = ptr_b_q;
    ptr_w_d = ptr_w_q;
    iter_d  = iter_q;
    ovf_d   = ovf_q;
    res_d   = res_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_INIT0;
          iter_d  = '0;
          ovf_d   = 1'b0;
          res_d   = '0;
        end
      end
      S_INIT0: begin
        state_d = S_INIT1;
        ptr_a_d = PTR_A0;
        ptr_b_d = PTR_B0;
        ptr_w_d = PTR_W0;
      end
      S_INIT1:  state_d = S_SELECT;
      S_SELECT: state_d = S_ADD;
      S_ADD:    state_d = S_WRITE;
      S_WRITE:  state_d = S_CMP;
      S_CMP: begin
        // The datapath limit takes priority over the cap, so a tie never flags overflow.
        if (mayor) begin
          state_d = S_DONE;
          res_d   = ptr_w_q;
        end else if (cap_hit) begin
          state_d = S_DONE;
          res_d   = ptr_w_q;
          ovf_d   = 1'b1;
        end else begin
          state_d = S_SELECT;
          ptr_a_d = ptr_b_q;
          ptr_b_d = ptr_w_q;
          ptr_w_d = (ptr_w_q == PTR_LAST) ? '0 : ptr_w_q + IW'(1);
          if (iter_q != ITER_SAT) iter_d = iter_q + CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state updates use <= so every flop samples the pre-edge value of its neighbours.
    if (rst) begin
      state_q <= S_IDLE;
      ptr_a_q <= PTR_A0;
      ptr_b_q <= PTR_B0;
      ptr_w_q <= PTR_W0;
      iter_q  <= '0;
      ovf_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_a_q <= ptr_a_d;
      ptr_b_q <= ptr_b_d;
      ptr_w_q <= ptr_w_d;
      iter_q  <= iter_d;
      ovf_q   <= ovf_d;
      res_q   <= res_d;
    end
  end

  // Control outputs are a pure decode of the state and pointer registers.
  always_comb begin
    alu_op = OP_HOLD;
    sel_a  = ptr_a_q;
    sel_b  = ptr_b_q;
    sel_w  = ptr_w_q;
    we     = 1'b0;
    busy   = 1'b1;
    done   = 1'b0;
    case (state_q)
      S_IDLE: begin
        alu_op = OP_ADD;
        sel_a  = '0;
        sel_b  = '0;
        sel_w  = '0;
        busy   = 1'b0;
      end
      S_INIT0: begin
        alu_op = OP_ZERO;
        sel_a  = '0;
        sel_b  = '0;
        sel_w  = PTR_A0;
        we     = 1'b1;
      end
      S_INIT1: begin
        alu_op = OP_ONE;
        sel_a  = '0;
        sel_b  = '0;
        sel_w  = PTR_B0;
        we     = 1'b1;
      end
      S_SELECT: alu_op = OP_HOLD;
      S_ADD:    alu_op = OP_ADD;
      S_WRITE: begin
        alu_op = OP_ADD;
        we     = 1'b1;
      end
      S_CMP:  alu_op = OP_HOLD;
      S_DONE: done   = 1'b1;
      default: begin
        alu_op = OP_ADD;
        busy   = 1'b0;
      end
    endcase
  end

  assign iter_count = iter_q;
  assign res_idx    = res_q;
  assign ovf        = CAP_EN ? ovf_q : 1'b0;

endmodule

// File: doc/fib_seq_ctrl.md
FIB_SEQ_CTRL -- requirements
Module: fib_seq_ctrl

Interface
REQ-001 Parameter NREG, default 3, register-file entries used in rotation (legal values 3..16).
REQ-002 Parameter CW, default 8, iteration-counter width.
REQ-003 Parameter MAX_ITER, default 200, iteration cap (below 2^CW); used only with ITER_LIMIT_EN.
REQ-004 Localparam IW = clog2(NREG), register-index width.
REQ-005 clk  in  1  clock; all state updates on its rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 start  in  1  run request; honoured only in IDLE.
REQ-008 mayor  in  1  datapath compare result: last written sum exceeds the limit.
REQ-009 alu_op  out  2  00 add, 01 hold, 10 load constant 0, 11 load constant 1.
REQ-010 sel_a, sel_b  out  IW  ALU source register indices.
REQ-011 sel_w  out  IW  write-destination register index.
REQ-012 we  out  1  register-file write enable.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 done  out  1  one-cycle pulse at end of run.
REQ-015 ovf  out  1  run ended by iteration cap; held until the next start.
REQ-016 iter_count  out  CW  completed non-terminal iterations of the current or last run.
REQ-017 res_idx  out  IW  index holding the final sum; held until the next start.

Function
REQ-018 States: IDLE, INIT0, INIT1, SELECT, ADD, WRITE, CMP, DONE.
REQ-019 Every output is defined in every state; no latches; outputs decode from the state register and pointer registers.
REQ-020 IDLE with start=1 goes to INIT0 and clears iter_count, ovf, and res_idx; start is ignored in all other states.
REQ-021 INIT0: alu_op=10, sel_w=0, we=1; INIT1: alu_op=11, sel_w=1, we=1; pointers load a=0, b=1, w=2.
REQ-022 SELECT: sel_a=ptr_a, sel_b=ptr_b, alu_op=01, we=0.
REQ-023 ADD: alu_op=00, we=0.
REQ-024 WRITE: alu_op=00, sel_w=ptr_w, we=1.
REQ-025 CMP: we=0; if mayor=1 (or the cap is hit), go to DONE with res_idx<=ptr_w; otherwise ptr_a<=ptr_b, ptr_b<=ptr_w, ptr_w<=(ptr_w+1) mod NREG, iter_count++, and return to SELECT.
REQ-026 ptr_w wraps from NREG-1 to 0.
REQ-027 Each iteration takes exactly 4 cycles; the first sum write occurs in the 5th cycle after start is sampled.
REQ-028 DONE: done=1 for one cycle, then IDLE unconditionally.
REQ-029 If mayor=1 and the cap are both true in CMP, mayor wins and ovf stays 0.
REQ-030 iter_count saturates at 2^CW-1 and never wraps.
REQ-031 In IDLE, sel_a, sel_b, sel_w, and alu_op are 0.

Reset
REQ-032 rst=1 forces IDLE with pointers a=0, b=1, w=2 and all outputs 0, at any time, including mid-run.
REQ-033 After rst deasserts, the block waits for a new start; an interrupted run does not resume.

Configuration
REQ-034 Macro FIB_SEQ_ITER_LIMIT_EN defined: in CMP, mayor=0 with iter_count==MAX_ITER goes to DONE with ovf<=1.
REQ-035 Macro FIB_SEQ_ITER_LIMIT_EN undefined: no cap; the run ends only on mayor; ovf is tied to 0.

Verification
REQ-036 NREG=3, bench datapath model, limit 20: sums 1,2,3,5,8,13,21 -> done pulse after 7 writes, iter_count=6, res_idx=2, ovf=0.
REQ-037 NREG=4: sel_w write sequence is 0,1,2,3,0,1; sources in the third iteration are a=2, b=3.
REQ-038 FIB_SEQ_ITER_LIMIT_EN defined, MAX_ITER=3, mayor held 0 -> 4 sum writes, done pulse, ovf=1, iter_count=3.
REQ-039 rst pulsed during the third ADD -> all outputs 0 in the same cycle, IDLE; a subsequent start reruns from INIT0.
REQ-040 start held high for 3 cycles, then start=1 again during the run -> a single run only; start is ignored while busy=1.
REQ-041 mayor=1 at the first CMP -> done after 1 write, iter_count=0, res_idx=2.
